// File: rtl/neopixel_pkg.sv
// Shared definitions for the WS2812 stream driver: pixel layout, FSM encoding
// and default 50 MHz bit timing.
package neopixel_pkg;

    localparam int BITS_PER_PIXEL = 24;

    // Wire order is G7 first, B0 last, so G occupies the top byte.
    typedef struct packed {
        logic [7:0] g;   // 23:16
        logic [7:0] r;   // 15:8
        logic [7:0] b;   // 7:0
    } grb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } np_state_t;

    localparam int DEF_T0H    = 20;
    localparam int DEF_T1H    = 40;
    localparam int DEF_TBIT   = 63;
    localparam int DEF_TLATCH = 4000;

endpackage

// File: rtl/neopixel_stream_driver_bit_tx.sv
// Serialises one 24-bit GRB word MSB first into WS2812 pulse-width bits.
// word_done marks the last counter cycle of bit 24; dout trails the counters by one clock.
module neopixel_bit_tx
    import neopixel_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [BITS_PER_PIXEL-1:0] word,
    output logic                      dout,
    output logic                      word_done
);

    localparam int TW = $clog2(TBIT);
    localparam int BW = $clog2(BITS_PER_PIXEL);
    localparam logic [TW-1:0] LAST_TIME = TW'(TBIT - 1);
    localparam logic [TW-1:0] HIGH0     = TW'(T0H);
    localparam logic [TW-1:0] HIGH1     = TW'(T1H);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_PIXEL - 1);

    logic [BITS_PER_PIXEL-1:0] shift_reg, shift_next;
    logic [TW-1:0]             time_reg, time_next;
    logic [BW-1:0]             bit_reg, bit_next;
    logic                      active_reg, active_next;
    logic                      dout_reg, dout_next;
    logic                      bit_end;

    always_comb begin
        shift_next  = shift_reg;
        time_next   = time_reg;
        bit_next    = bit_reg;
        active_next = active_reg;
        bit_end     = active_reg && (time_reg == LAST_TIME);
        word_done   = bit_end && (bit_reg == LAST_BIT);

        // A load on the word_done cycle keeps bit periods back to back.
        if (load) begin
            shift_next  = word;
            time_next   = '0;
            bit_next    = '0;
            active_next = 1'b1;
        end else if (word_done) begin
            active_next = 1'b0;
            time_next   = '0;
            bit_next    = '0;
        end else if (bit_end) begin
            shift_next = {shift_reg[BITS_PER_PIXEL-2:0], 1'b0};
            time_next  = '0;
            bit_next   = bit_reg + 1'b1;
        end else if (active_reg) begin
            time_next = time_reg + 1'b1;
        end

        dout_next = active_reg &&
                    (time_reg < (shift_reg[BITS_PER_PIXEL-1] ? HIGH1 : HIGH0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            time_reg   <= '0;
            bit_reg    <= '0;
            active_reg <= 1'b0;
            dout_reg   <= 1'b0;
        end else begin
            shift_reg  <= shift_next;
            time_reg   <= time_next;
            bit_reg    <= bit_next;
            active_reg <= active_next;
            dout_reg   <= dout_next;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/neopixel_stream_driver.sv
// WS2812 frame streamer: fetches pixels from an external source with a
// one-pixel prefetch, serialises them and holds the latch gap.
module neopixel_stream_driver
    import neopixel_pkg::*;
#(
    parameter int NUM_LEDS = 64,
    parameter int IDX_W    = 7,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TLATCH   = DEF_TLATCH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      auto_refresh,
    output logic                      pix_req,
    output logic [IDX_W-1:0]          pix_idx,
    input  logic                      pix_valid,
    input  logic [BITS_PER_PIXEL-1:0] pix_grb,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      underrun,
    output logic                      dout
);

    localparam int LW = (TLATCH > 1) ? $clog2(TLATCH) : 1;
    localparam logic [LW-1:0]    LATCH_LAST = LW'(TLATCH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEDS - 1);

    np_state_t                 state_reg, state_next;
    logic [IDX_W-1:0]          pix_idx_reg, pix_idx_next;
    logic [IDX_W-1:0]          cur_idx_reg, cur_idx_next;
    grb_t                      hold_reg, hold_next;
    logic                      hold_full_reg, hold_full_next;
    logic                      req_reg, req_next;
    logic [LW-1:0]             latch_reg, latch_next;
    logic                      complete_reg, complete_next;

    logic                      tx_load;
    logic [BITS_PER_PIXEL-1:0] tx_word;
    logic                      tx_done;
    logic [IDX_W-1:0]          nxt_idx;
    logic                      more_after;

    neopixel_bit_tx #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .word      (tx_word),
        .dout      (dout),
        .word_done (tx_done)
    );

    assign nxt_idx    = cur_idx_reg + 1'b1;
    assign more_after = (nxt_idx != LAST_IDX);

    always_comb begin
        state_next     = state_reg;
        pix_idx_next   = pix_idx_reg;
        cur_idx_next   = cur_idx_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        req_next       = req_reg;
        latch_next     = latch_reg;
        complete_next  = complete_reg;
        pix_req        = 1'b0;
        tx_load        = 1'b0;
        tx_word        = hold_reg;
        frame_done     = 1'b0;
        underrun       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start || auto_refresh) begin
                    state_next     = ST_PRIME;
                    pix_idx_next   = '0;
                    hold_full_next = 1'b0;
                    req_next       = 1'b0;
                end
            end

            ST_PRIME: begin
                pix_req = 1'b1;
                if (pix_valid) begin
                    tx_load      = 1'b1;
                    tx_word      = pix_grb;
                    cur_idx_next = '0;
                    pix_idx_next = IDX_W'(1);
                    req_next     = (LAST_IDX != '0);
                    state_next   = ST_SEND;
                end
            end

            ST_SEND: begin
                pix_req = req_reg;
                if (req_reg && pix_valid) begin
                    hold_next      = pix_grb;
                    hold_full_next = 1'b1;
                    req_next       = 1'b0;
                end
                if (tx_done) begin
                    if (cur_idx_reg == LAST_IDX) begin
                        state_next    = ST_LATCH;
                        latch_next    = '0;
                        complete_next = 1'b1;
                    // A pixel accepted exactly on the boundary is used directly rather than dropped.
                    end else if (hold_full_reg || (req_reg && pix_valid)) begin
                        tx_load        = 1'b1;
                        tx_word        = hold_full_reg ? hold_reg : pix_grb;
                        hold_full_next = 1'b0;
                        req_next       = more_after;
                        cur_idx_next   = nxt_idx;
                        if (more_after) begin
                            pix_idx_next = pix_idx_reg + 1'b1;
                        end
                    end else begin
                        underrun       = 1'b1;
                        req_next       = 1'b0;
                        hold_full_next = 1'b0;
                        state_next     = ST_LATCH;
                        latch_next     = '0;
                        complete_next  = 1'b0;
                    end
                end
            end

            ST_LATCH: begin
                if (latch_reg == LATCH_LAST) begin
                    frame_done = complete_reg;
                    if (auto_refresh) begin
                        state_next     = ST_PRIME;
                        pix_idx_next   = '0;
                        hold_full_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    latch_next = latch_reg + 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pix_idx_reg   <= '0;
            cur_idx_reg   <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            req_reg       <= 1'b0;
            latch_reg     <= '0;
            complete_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pix_idx_reg   <= pix_idx_next;
            cur_idx_reg   <= cur_idx_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            req_reg       <= req_next;
            latch_reg     <= latch_next;
            complete_reg  <= complete_next;
        end
    end

    assign pix_idx = pix_idx_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_neopixel_stream_driver.sv
// Frame-level bench: a pixel source answers requests, every dout sample is
// compared against a waveform built from the WS2812 bit rules.
module tb_neopixel_stream_driver;

    localparam int N      = 3;
    localparam int IW     = 2;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TLATCH = 10;
    localparam int PIXT   = 24 * TBIT;
    localparam int LOGMAX = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          auto_refresh = 1'b0;
    logic          pix_valid = 1'b0;
    logic [23:0]   pix_grb = '0;
    logic          pix_req, busy, frame_done, underrun, dout;
    logic [IW-1:0] pix_idx;

    neopixel_stream_driver #(
        .NUM_LEDS (N), .IDX_W (IW), .T0H (T0H), .T1H (T1H),
        .TBIT (TBIT), .TLATCH (TLATCH)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .auto_refresh (auto_refresh),
        .pix_req (pix_req), .pix_idx (pix_idx), .pix_valid (pix_valid),
        .pix_grb (pix_grb), .busy (busy), .frame_done (frame_done),
        .underrun (underrun), .dout (dout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [N-1:0][23:0] px;
        logic [N-1:0][7:0]  dly;
        int                 withhold;
        bit                 hold_start;
        bit                 spurious;
        int                 exp_fd;
        int                 exp_ur;
    } vec_t;

    function automatic vec_t make_vec(input logic [23:0] p0, p1, p2,
                                      input int d0, d1, d2, wh,
                                      input bit hs, sp, input int fd, ur);
        vec_t v;
        v.px[0] = p0; v.px[1] = p1; v.px[2] = p2;
        v.dly[0] = 8'(d0); v.dly[1] = 8'(d1); v.dly[2] = 8'(d2);
        v.withhold = wh; v.hold_start = hs; v.spurious = sp;
        v.exp_fd = fd; v.exp_ur = ur;
        return v;
    endfunction

    // Pixel source
    logic [23:0] src_px [N];
    int          src_dly [N];
    int          src_withhold = -1;
    bit          src_spurious = 1'b0;
    bit          src_on = 1'b0;

    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (src_on && pix_req && int'(pix_idx) < N && int'(pix_idx) != src_withhold) begin
                if (wait_cnt >= src_dly[pix_idx]) begin
                    pix_valid = 1'b1;
                    pix_grb   = src_px[pix_idx];
                    wait_cnt  = 0;
                end else begin
                    pix_valid = 1'b0;
                    pix_grb   = $urandom;
                    wait_cnt++;
                end
            end else begin
                wait_cnt  = 0;
                pix_valid = src_on && src_spurious && !pix_req && ($urandom_range(0, 1) == 1);
                pix_grb   = $urandom;
            end
        end
    end

    // Sample log, one entry per clock, taken on the falling edge
    bit   rec_on = 1'b0;
    int   ns = 0;
    int   last_busy = -1;
    logic log_dout [LOGMAX];
    logic exp_w [LOGMAX];
    int   acc_idx[$];
    int   acc_smp[$];
    int   fd_smp[$];
    int   ur_smp[$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rec_on && ns < LOGMAX) begin
                log_dout[ns] = dout;
                if (busy) last_busy = ns;
                if (pix_req && pix_valid) begin
                    acc_idx.push_back(int'(pix_idx));
                    acc_smp.push_back(ns);
                end
                if (frame_done) fd_smp.push_back(ns);
                if (underrun) ur_smp.push_back(ns);
                ns++;
            end
        end
    end

    task automatic load_src(input vec_t v);
        for (int p = 0; p < N; p++) begin
            src_px[p]  = v.px[p];
            src_dly[p] = int'(v.dly[p]);
        end
    endtask

    task automatic run_txn(input string name, input int withhold, input bit hold_start,
                           input bit spurious, input bit use_auto,
                           input int exp_fd, input int exp_ur);
        int  frames, sent, cyc, mism, first_bad, exp_end;
        bit  done, complete;
        int  a_list[$];
        int  exp_idx[$];
        @(posedge clk); #1;
        acc_idx.delete(); acc_smp.delete(); fd_smp.delete(); ur_smp.delete();
        ns = 0; last_busy = -1;
        src_withhold = withhold; src_spurious = spurious; src_on = 1'b1; rec_on = 1'b1;
        if (use_auto) auto_refresh = 1'b1;
        else start = 1'b1;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_start || (fd_smp.size() + ur_smp.size()) > 0) start = 1'b0;
            if (use_auto && fd_smp.size() > 0) auto_refresh = 1'b0;
            if (!busy) done = 1'b1;
        end
        rec_on = 1'b0; src_on = 1'b0; start = 1'b0; auto_refresh = 1'b0;
        check({name, " completes"}, int'(done), 1);
        if (!done) begin
            rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
            return;
        end

        frames   = use_auto ? 2 : 1;
        complete = (withhold < 0);
        sent     = complete ? N : withhold;

        foreach (acc_idx[i]) if (acc_idx[i] == 0) a_list.push_back(acc_smp[i]);
        check({name, " frame_count"}, a_list.size(), frames);
        check({name, " frame_done_count"}, fd_smp.size(), exp_fd);
        check({name, " underrun_count"}, ur_smp.size(), exp_ur);

        for (int f = 0; f < frames; f++)
            for (int p = 0; p < sent; p++) exp_idx.push_back(p);
        mism = (acc_idx.size() == exp_idx.size()) ? 0 : 1;
        for (int i = 0; i < acc_idx.size() && i < exp_idx.size(); i++)
            if (acc_idx[i] != exp_idx[i]) mism++;
        check({name, " index_sequence_errors"}, mism, 0);

        if (a_list.size() == frames) begin
            check({name, " first_accept_sample"}, a_list[0], 1 + src_dly[0]);
            if (frames == 2 && fd_smp.size() > 0)
                check({name, " reprime_accept_sample"}, a_list[1], fd_smp[0] + 1 + src_dly[0]);

            for (int t = 0; t < LOGMAX; t++) exp_w[t] = 1'b0;
            for (int f = 0; f < frames; f++) begin
                for (int t = 0; t < sent * PIXT; t++) begin
                    int  j, p, b, ph, s;
                    logic [23:0] px;
                    j = t / TBIT; p = j / 24; b = 23 - (j % 24); ph = t % TBIT;
                    px = src_px[p];
                    s = a_list[f] + 2 + t;
                    if (s < LOGMAX) exp_w[s] = (ph < (px[b] ? T1H : T0H));
                end
                if (complete && f < fd_smp.size())
                    check({name, " frame_done_sample"}, fd_smp[f], a_list[f] + N * PIXT + TLATCH);
                if (!complete && f < ur_smp.size())
                    check({name, " underrun_sample"}, ur_smp[f], a_list[f] + sent * PIXT);
            end
            mism = 0; first_bad = -1;
            for (int t = 0; t < ns; t++)
                if (log_dout[t] !== exp_w[t]) begin
                    mism++;
                    if (first_bad < 0) first_bad = t;
                end
            if (mism != 0) $display("  %s: first dout difference at sample %0d", name, first_bad);
            check({name, " dout_waveform_errors"}, mism, 0);
            exp_end = a_list[frames-1] + sent * PIXT + TLATCH;
            check({name, " last_busy_sample"}, last_busy, exp_end);
        end
        $display("txn %s: accepts=%0d frame_done=%0d underrun=%0d samples=%0d",
                 name, acc_idx.size(), fd_smp.size(), ur_smp.size(), ns);
    endtask

    vec_t vecs [5];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t v;
        bit   found;
        vecs[0] = make_vec(24'hFF0000, 24'h00AA00, 24'h000001, 1, 1, 1, -1, 0, 0, 1, 0);
        vecs[1] = make_vec(24'hFF0000, 24'h00AA00, 24'h000001, 20, 1, 1, -1, 0, 0, 1, 0);
        vecs[2] = make_vec(24'h123456, 24'hABCDEF, 24'h0F0F0F, 1, 1, 1, 2, 0, 0, 0, 1);
        vecs[3] = make_vec(24'h800001, 24'hFFFFFF, 24'h000000, 0, 3, 3, 1, 0, 0, 0, 1);
        vecs[4] = make_vec(24'hC3A55A, 24'h5AA5C3, 24'hF00F81, 2, 0, 7, -1, 1, 1, 1, 0);

        #12;
        check("reset dout", int'(dout), 0);
        check("reset busy", int'(busy), 0);
        check("reset pix_req", int'(pix_req), 0);
        check("reset pix_idx", int'(pix_idx), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset underrun", int'(underrun), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            load_src(vecs[i]);
            run_txn($sformatf("table%0d", i), vecs[i].withhold, vecs[i].hold_start,
                    vecs[i].spurious, 1'b0, vecs[i].exp_fd, vecs[i].exp_ur);
        end

        // Asynchronous reset while pixel 1 is on the wire
        v = vecs[0];
        v.dly[2] = 8'd60;
        load_src(v);
        src_withhold = -1; src_spurious = 1'b0; src_on = 1'b1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(posedge clk); #1;
            if (pix_req && pix_idx == 2'd2 && dout) found = 1'b1;
        end
        check("midsend reached", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset dout", int'(dout), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset pix_req", int'(pix_req), 0);
        check("async reset pix_idx", int'(pix_idx), 0);
        src_on = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        $display("txn midsend_reset: reset applied during pixel 1");
        load_src(vecs[0]);
        run_txn("restart", -1, 1'b0, 1'b0, 1'b0, 1, 0);

        load_src(vecs[0]);
        run_txn("auto_refresh", -1, 1'b0, 1'b0, 1'b1, 2, 0);

        for (int r = 0; r < 6; r++) begin
            int k, wh;
            v.px[0] = 24'($urandom); v.px[1] = 24'($urandom); v.px[2] = 24'($urandom);
            v.dly[0] = 8'($urandom_range(0, 25));
            v.dly[1] = 8'($urandom_range(0, 40));
            v.dly[2] = 8'($urandom_range(0, 40));
            k = $urandom_range(0, 3);
            wh = (k == 2) ? 1 : (k == 3) ? 2 : -1;
            load_src(v);
            run_txn($sformatf("rand%0d", r), wh, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, (wh < 0) ? 1 : 0, (wh < 0) ? 0 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neopixel_stream_driver.md
Name: neopixel_stream_driver

Overview:
Parametrised WS2812/NeoPixel serial driver that streams a full frame of 24-bit GRB pixels from an external pixel source onto one data line, then holds the latch/reset gap. It replaces fixed on/off-only LED drivers: per-pixel full colour, configurable LED count and bit timing, prefetch of the next pixel, single-shot or auto-refresh modes. Sits between game/render logic (the pixel source) and the matrix output pin.

Parameters:
NUM_LEDS, 64, pixels per frame (>=1)
IDX_W, 7, width of pixel index; must satisfy 2**IDX_W >= NUM_LEDS
T0H, 20, clocks high for a '0' bit (0.4 us at 50 MHz)
T1H, 40, clocks high for a '1' bit (0.8 us at 50 MHz)
TBIT, 63, clocks per bit period; T0H < T1H < TBIT
TLATCH, 4000, clocks of low level after the frame (80 us at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE, begins one frame
auto_refresh  in  1  1 = restart immediately after every latch gap
pix_req  out  1  pixel request, held until accepted
pix_idx  out  IDX_W  index of requested pixel, stable while pix_req=1
pix_valid  in  1  accepts request; pix_grb sampled this cycle
pix_grb  in  24  {G[7:0],R[7:0],B[7:0]}
busy  out  1  1 in any state except IDLE
frame_done  out  1  one-cycle pulse at end of latch gap after a complete frame
underrun  out  1  one-cycle pulse when a frame is aborted for lack of data
dout  out  1  serial data to first LED

Behaviour:
- Reset (async, rst_n=0): state IDLE, dout=0, pix_req=0, pix_idx=0, busy=0, frame_done=0, underrun=0, prefetch buffer empty.
- States: IDLE, PRIME, SEND, LATCH.
- IDLE: when start=1 or auto_refresh=1 -> PRIME next cycle, pix_idx=0.
- PRIME: pix_req=1 for pixel 0; on pix_valid load shift register, advance pix_idx to 1 -> SEND next cycle. No timeout; dout stays 0.
- SEND: 24 bits MSB first (G7 first, B0 last). Each bit: dout=1 for T1H (bit=1) or T0H (bit=0) clocks from bit start, 0 for remainder of TBIT. First bit of pixel 0 begins the cycle after entering SEND.
- Prefetch: during SEND of pixel k (k < NUM_LEDS-1), pix_req=1 with pix_idx=k+1 from the first cycle of pixel k until pix_valid; accepted data goes into a 24-bit holding register; pix_req then 0 until the next pixel starts.
- Pixel boundary: at the end of bit 24 of pixel k, if holding register full -> load shift register, next bit starts the following cycle with no gap (bit periods contiguous, exactly TBIT each).
- Underrun: holding register empty at that boundary -> underrun pulse, pix_req dropped, -> LATCH; frame_done not asserted for this frame.
- Last pixel (k = NUM_LEDS-1): no prefetch; after its 24th bit -> LATCH.
- LATCH: dout=0 for TLATCH clocks. At end: frame_done pulse (complete frames only); then PRIME if auto_refresh=1, else IDLE.
- start while busy: ignored. Changes to auto_refresh take effect only at the end of LATCH.
- pix_valid while pix_req=0: ignored.
- Counters: bit-time counter sized for TBIT-1, bit counter 0..23, pixel index wraps to 0 only via PRIME. Full frame length = (24*NUM_LEDS*TBIT) + TLATCH clocks plus PRIME wait.
- dout is registered (glitch-free).

Decomposition:
- Shared package neopixel_pkg: GRB field offsets (G 23:16, R 15:8, B 7:0), BITS_PER_PIXEL=24, state encoding for IDLE/PRIME/SEND/LATCH, default timing constants for 50 MHz.
- Sub-module neopixel_bit_tx: loads 24-bit word, produces dout waveform, outputs word_done pulse on the last cycle of bit 24; the top holds FSM, prefetch buffer and index logic.

Test Plan:
Use NUM_LEDS=3, T0H=2, T1H=4, TBIT=6, TLATCH=10.
1. Reset mid-SEND (rst_n low during pixel 1) -> dout=0, busy=0, pix_req=0 asynchronously; restart sends from pixel 0.
2. start pulse, source returns 0xFF0000, 0x00AA00, 0x000001 with pix_valid 1 cycle after req -> dout shows 72 bits of 6 clocks each, highs of 4/2 clocks matching MSB-first data, no gaps, then 10 low clocks, frame_done once; busy=0 afterwards.
3. pix_valid delayed 20 clocks in PRIME -> dout stays 0 for the delay; frame timing thereafter identical to scenario 2.
4. Withhold pix_valid for pixel 2 -> underrun pulses at end of pixel 1, LATCH of 10 clocks, no frame_done, returns to IDLE.
5. auto_refresh=1 -> second PRIME starts the cycle after the first frame_done; pix_idx sequence 0,1,2,0,1,2.
6. start held high during SEND, and pix_valid asserted with pix_req=0 -> no effect on waveform or index.
